mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single-port 256x8 data/instruction memory between the instruction-fetch stage (IF, read-only) and the memory stage (DM, read/write).
- Registers the winning request, drives the memory's address/data/enable pins for one access cycle, captures read data, and returns a one-cycle ack.
- DM has priority. A burst limit guarantees IF forward progress.
- Sits between the pipeline's IF/MEM stages and the Memory instance.

Parameters:
- MAX_DM_BURST, 3: consecutive DM grants allowed while IF is pending before IF is forced in; legal range 1..15.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge
- RST_n  input  1  asynchronous active-low reset
- IF_Req  input  1  IF request; held with IF_Addr stable until IF_Ack
- IF_Addr  input  8  IF read address
- IF_Ack  output  1  one-cycle pulse: IF access complete, IF_Rdata valid
- IF_Rdata  output  8  registered IF read data
- DM_Req  input  1  DM request; held with DM_We/DM_Addr/DM_Wdata stable until DM_Ack
- DM_We  input  1  1 = write, 0 = read
- DM_Addr  input  8  DM address
- DM_Wdata  input  8  DM write data
- DM_Ack  output  1  one-cycle pulse: DM access complete (read data valid if read)
- DM_Rdata  output  8  registered DM read data
- Mem_Address  output  8  to memory Address
- Mem_Data_in  output  8  to memory Data_in
- Mem_W_En  output  1  to memory W_En
- Mem_R_En  output  1  to memory R_En
- Mem_Data_out  input  8  from memory Data_out (asynchronous read)
- Busy  output  1  high in ACCESS and DONE

Behaviour:
- Reset (async, RST_n low): state=IDLE, owner=none, burst counter=0. All outputs 0, including both Rdata registers and all Mem_* signals. A write in flight is aborted: Mem_W_En drops immediately.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. One transaction takes 3 cycles; no pipelining.
- IDLE:
  - At the rising edge, if any Req is high, select the winner and latch its addr, wdata, we and owner. Next state is ACCESS.
  - If no Req is high, stay in IDLE.
  - Mem_R_En=0 and Mem_W_En=0 in this state.
- Selection:
  - Only one Req high: that requester wins.
  - Both high: DM wins unless burst counter == MAX_DM_BURST, in which case IF wins.
- Burst counter (4 bits):
  - Increments on a DM grant while IF_Req is high.
  - Clears on any IF grant.
  - Holds otherwise.
  - Never exceeds MAX_DM_BURST.
- ACCESS:
  - Mem_Address = latched addr.
  - Mem_W_En = latched we. Mem_R_En = ~latched we. Mem_Data_in = latched wdata (0 when reading).
  - At the edge: for a read, capture Mem_Data_out into the owner's Rdata register. Set the owner's Ack register. Next state is DONE.
  - The write commits in the memory at the same edge.
- DONE:
  - The owner's Ack is high for exactly this cycle. Mem_* are 0.
  - Requests are ignored. The requester drops Req or presents a new request at the edge ending DONE.
  - Next state is IDLE.
- Rdata registers change only on reads completed by their own port. Writes leave DM_Rdata unchanged.
- IF_Ack and DM_Ack are never high together. Mem_W_En and Mem_R_En are never high together.
- A Req that drops before being granted is simply not served; a Req that drops mid-transaction does not cancel it (the access completes and Ack pulses).
- Write-then-read to the same address by DM returns the new data: the write commits at the end of ACCESS, two cycles before the next ACCESS.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- Defined: adds ports Stats_Clr (input, 1) and Conflict_Count (output, 8).
  - Conflict_Count increments at each IDLE edge where IF_Req and DM_Req are both high.
  - It saturates at 255.
  - Synchronous clear when Stats_Clr is high; clear has priority over increment.
  - Async reset to 0.
- Undefined: neither port nor the counter exists; all other behaviour is identical.

Test Plan:
- Reset mid-write: DM write 0xA5 to 0x10, assert RST_n low during ACCESS -> Mem_W_En=0 immediately; all outputs 0; after release, a DM read of 0x10 returns the pre-existing value, not 0xA5.
- Single IF read: memory[0x20]=0x3C, IF_Req with addr 0x20 -> Mem_R_En=1 and Mem_Address=0x20 in cycle 2; IF_Ack=1 and IF_Rdata=0x3C in cycle 3; DM_Ack stays 0.
- DM write then read-back: write 0x7E to 0xFF, then read 0xFF -> DM_Rdata=0x7E on the second DM_Ack; DM_Rdata unchanged after the write ack.
- Priority and starvation, MAX_DM_BURST=3: IF_Req and DM_Req held continuously (DM re-requesting after each ack) -> grant order DM, DM, DM, IF, DM, DM, DM, IF; acks never coincide.
- Simultaneous first request with counter=0 -> DM is served first; IF_Ack arrives 3 cycles after DM_Ack.
- MEM_ARB_STATS_EN defined: 5 arbitration edges with both Req high -> Conflict_Count=5; Stats_Clr for one cycle -> 0; 300 conflicts -> saturates at 255.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one 256x8 async-read memory between IF (read-only) and DM (read/write); DM has priority with a burst limit.
// Optional build macro MEM_ARB_STATS_EN adds Stats_Clr / Conflict_Count.
module mem_port_arbiter #(
  parameter int unsigned MAX_DM_BURST = 3
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       IF_Req,
  input  logic [7:0] IF_Addr,
  output logic       IF_Ack,
  output logic [7:0] IF_Rdata,
  input  logic       DM_Req,
  input  logic       DM_We,
  input  logic [7:0] DM_Addr,
  input  logic [7:0] DM_Wdata,
  output logic       DM_Ack,
  output logic [7:0] DM_Rdata,
`ifdef MEM_ARB_STATS_EN
  input  logic       Stats_Clr,
  output logic [7:0] Conflict_Count,
`endif
  output logic [7:0] Mem_Address,
  output logic [7:0] Mem_Data_in,
  output logic       Mem_W_En,
  output logic       Mem_R_En,
  input  logic [7:0] Mem_Data_out,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t     state, next_state;
  logic       owner_dm;
  logic       lat_we;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [3:0] burst_cnt;
  logic       any_req;
  logic       burst_at_max;
  logic       grant_dm;

  assign any_req      = IF_Req | DM_Req;
  assign burst_at_max = (burst_cnt == 4'(MAX_DM_BURST));
  // IF only beats a pending DM once DM has used up its burst allowance
  assign grant_dm     = DM_Req & ~(IF_Req & burst_at_max);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state  = state;
    Mem_Address = 8'h00;
    Mem_Data_in = 8'h00;
    Mem_W_En    = 1'b0;
    Mem_R_En    = 1'b0;
    Busy        = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) next_state = ACCESS;
      end
      ACCESS: begin
        next_state  = DONE;
        Busy        = 1'b1;
        Mem_Address = lat_addr;
        Mem_Data_in = lat_wdata;
        Mem_W_En    = lat_we;
        Mem_R_En    = ~lat_we;
      end
      DONE: begin
        next_state = IDLE;
        Busy       = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      owner_dm  <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 8'h00;
      lat_wdata <= 8'h00;
      burst_cnt <= 4'd0;
      IF_Ack    <= 1'b0;
      DM_Ack    <= 1'b0;
      IF_Rdata  <= 8'h00;
      DM_Rdata  <= 8'h00;
    end else begin
      IF_Ack <= 1'b0;
      DM_Ack <= 1'b0;
      if (state == IDLE && any_req) begin
        owner_dm  <= grant_dm;
        lat_addr  <= grant_dm ? DM_Addr : IF_Addr;
        lat_we    <= grant_dm & DM_We;
        lat_wdata <= (grant_dm && DM_We) ? DM_Wdata : 8'h00;
        if (!grant_dm)
          burst_cnt <= 4'd0;
        else if (IF_Req && !burst_at_max)
          burst_cnt <= burst_cnt + 4'd1;
      end
      if (state == ACCESS) begin
        if (owner_dm) begin
          DM_Ack <= 1'b1;
          if (!lat_we) DM_Rdata <= Mem_Data_out;
        end else begin
          IF_Ack   <= 1'b1;
          IF_Rdata <= Mem_Data_out;
        end
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)
      Conflict_Count <= 8'h00;
    else if (Stats_Clr)
      Conflict_Count <= 8'h00;
    else if (state == IDLE && IF_Req && DM_Req && Conflict_Count != 8'hFF)
      Conflict_Count <= Conflict_Count + 8'h01;
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural async-read memory attached.
module tb_mem_port_arbiter;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic       IF_Req;
  logic [7:0] IF_Addr;
  logic       IF_Ack;
  logic [7:0] IF_Rdata;
  logic       DM_Req;
  logic       DM_We;
  logic [7:0] DM_Addr;
  logic [7:0] DM_Wdata;
  logic       DM_Ack;
  logic [7:0] DM_Rdata;
  logic [7:0] Mem_Address;
  logic [7:0] Mem_Data_in;
  logic       Mem_W_En;
  logic       Mem_R_En;
  logic [7:0] Mem_Data_out;
  logic       Busy;
`ifdef MEM_ARB_STATS_EN
  logic       Stats_Clr;
  logic [7:0] Conflict_Count;
`endif

  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_dat;
  logic [7:0] mem [256];

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(.MAX_DM_BURST(3)) dut (
    .CLK(CLK), .RST_n(RST_n),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ack(IF_Ack), .IF_Rdata(IF_Rdata),
    .DM_Req(DM_Req), .DM_We(DM_We), .DM_Addr(DM_Addr), .DM_Wdata(DM_Wdata),
    .DM_Ack(DM_Ack), .DM_Rdata(DM_Rdata),
`ifdef MEM_ARB_STATS_EN
    .Stats_Clr(Stats_Clr), .Conflict_Count(Conflict_Count),
`endif
    .Mem_Address(Mem_Address), .Mem_Data_in(Mem_Data_in),
    .Mem_W_En(Mem_W_En), .Mem_R_En(Mem_R_En),
    .Mem_Data_out(Mem_Data_out), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ld_en)         mem[ld_addr]     <= ld_dat;
    else if (Mem_W_En) mem[Mem_Address] <= Mem_Data_in;
  end
  assign Mem_Data_out = mem[Mem_Address];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_addr = a;
    ld_dat  = d;
    tick();
  endtask

  // Holds both requests high for n complete transactions (one IDLE edge each)
  task automatic run_both(input int n);
    IF_Req = 1'b1; IF_Addr = 8'h20;
    DM_Req = 1'b1; DM_We = 1'b0; DM_Addr = 8'h10;
    for (int k = 0; k < n; k++) begin
      tick(); tick(); tick();
    end
    IF_Req = 1'b0;
    DM_Req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST_n = 1'b0;
    IF_Req = 1'b0; IF_Addr = 8'h00;
    DM_Req = 1'b0; DM_We = 1'b0; DM_Addr = 8'h00; DM_Wdata = 8'h00;
    ld_en = 1'b0; ld_addr = 8'h00; ld_dat = 8'h00;
`ifdef MEM_ARB_STATS_EN
    Stats_Clr = 1'b0;
`endif
    #1;
    ld_en = 1'b1;
    load(8'h10, 8'h11);
    load(8'h20, 8'h3C);
    load(8'hFF, 8'h00);
    ld_en = 1'b0;

    check("rst_if_ack",   8'(IF_Ack),   8'h00);
    check("rst_dm_ack",   8'(DM_Ack),   8'h00);
    check("rst_if_rdata", IF_Rdata,     8'h00);
    check("rst_dm_rdata", DM_Rdata,     8'h00);
    check("rst_mem_addr", Mem_Address,  8'h00);
    check("rst_mem_ren",  8'(Mem_R_En), 8'h00);
    check("rst_busy",     8'(Busy),     8'h00);
    RST_n = 1'b1;
    tick();

    // Write aborted by reset during ACCESS
    DM_Req = 1'b1; DM_We = 1'b1; DM_Addr = 8'h10; DM_Wdata = 8'hA5;
    tick();
    check("abort_wen_before", 8'(Mem_W_En), 8'h01);
    check("abort_din_before", Mem_Data_in,  8'hA5);
    #2 RST_n = 1'b0;
    #1;
    check("abort_wen_after", 8'(Mem_W_En), 8'h00);
    check("abort_din_after", Mem_Data_in,  8'h00);
    check("abort_addr",      Mem_Address,  8'h00);
    check("abort_busy",      8'(Busy),     8'h00);
    check("abort_dm_ack",    8'(DM_Ack),   8'h00);
    DM_Req = 1'b0; DM_We = 1'b0;
    tick();
    RST_n = 1'b1;
    tick();
    DM_Req = 1'b1; DM_We = 1'b0; DM_Addr = 8'h10;
    tick();
    check("abort_rd_ren", 8'(Mem_R_En), 8'h01);
    tick();
    check("abort_rd_ack",   8'(DM_Ack), 8'h01);
    check("abort_rd_rdata", DM_Rdata,   8'h11);
    DM_Req = 1'b0;
    tick();
    check("abort_rd_ack_drop", 8'(DM_Ack), 8'h00);

    // Single IF read
    IF_Req = 1'b1; IF_Addr = 8'h20;
    tick();
    check("if_ren",  8'(Mem_R_En),    8'h01);
    check("if_wen",  8'(Mem_W_En),    8'h00);
    check("if_addr", Mem_Address,     8'h20);
    check("if_busy", 8'(Busy),        8'h01);
    tick();
    check("if_ack",    8'(IF_Ack), 8'h01);
    check("if_rdata",  IF_Rdata,   8'h3C);
    check("if_dm_ack", 8'(DM_Ack), 8'h00);
    check("if_idle_mem", 8'(Mem_R_En), 8'h00);
    IF_Req = 1'b0;
    tick();
    check("if_ack_pulse", 8'(IF_Ack), 8'h00);
    check("if_busy_done", 8'(Busy),   8'h00);

    // DM write 0x7E to 0xFF, then read it back
    DM_Req = 1'b1; DM_We = 1'b1; DM_Addr = 8'hFF; DM_Wdata = 8'h7E;
    tick();
    check("wr_wen", 8'(Mem_W_En), 8'h01);
    check("wr_ren", 8'(Mem_R_En), 8'h00);
    check("wr_din", Mem_Data_in,  8'h7E);
    tick();
    check("wr_ack",       8'(DM_Ack), 8'h01);
    check("wr_rdata_old", DM_Rdata,   8'h11);
    DM_We = 1'b0;
    tick();
    tick();
    check("rb_ren", 8'(Mem_R_En), 8'h01);
    check("rb_din", Mem_Data_in,  8'h00);
    tick();
    check("rb_ack",   8'(DM_Ack), 8'h01);
    check("rb_rdata", DM_Rdata,   8'h7E);
    DM_Req = 1'b0;
    tick();

    // Starvation guard: D D D I D D D I
    IF_Req = 1'b1; IF_Addr = 8'h20;
    DM_Req = 1'b1; DM_We = 1'b0; DM_Addr = 8'h10;
    for (int i = 0; i < 8; i++) begin
      tick();
      tick();
      check($sformatf("burst_dm_ack_%0d", i), 8'(DM_Ack), (i % 4 == 3) ? 8'h00 : 8'h01);
      check($sformatf("burst_if_ack_%0d", i), 8'(IF_Ack), (i % 4 == 3) ? 8'h01 : 8'h00);
      tick();
    end
    IF_Req = 1'b0; DM_Req = 1'b0;
    tick();

    // Simultaneous first request after an IF grant: DM first, IF 3 cycles later
    IF_Req = 1'b1; DM_Req = 1'b1; DM_Addr = 8'hFF;
    tick();
    tick();
    check("sim_dm_ack", 8'(DM_Ack), 8'h01);
    check("sim_if_ack", 8'(IF_Ack), 8'h00);
    check("sim_dm_rd",  DM_Rdata,   8'h7E);
    DM_Req = 1'b0;
    tick();
    tick();
    check("sim_if_pending", 8'(IF_Ack), 8'h00);
    tick();
    check("sim_if_ack_late", 8'(IF_Ack), 8'h01);
    check("sim_dm_ack_late", 8'(DM_Ack), 8'h00);
    IF_Req = 1'b0;
    tick();

`ifdef MEM_ARB_STATS_EN
    Stats_Clr = 1'b1;
    tick();
    Stats_Clr = 1'b0;
    check("stats_clr0", Conflict_Count, 8'h00);
    run_both(5);
    check("stats_five", Conflict_Count, 8'h05);
    Stats_Clr = 1'b1;
    tick();
    Stats_Clr = 1'b0;
    check("stats_clr", Conflict_Count, 8'h00);
    run_both(300);
    check("stats_sat", Conflict_Count, 8'hFF);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
